// File: rtl/traffic_controller_param.sv
// Parametrised intersection light controller: main/side lights, pedestrian walk interval and a
// flashing night mode, all timed from a one-second tick divided down from clk.
module traffic_controller_param #(
  parameter int unsigned CLK_DIV  = 100_000_000,
  parameter int unsigned TVAL_W   = 4,
  parameter int unsigned DEF_BASE = 6,
  parameter int unsigned DEF_EXT  = 3,
  parameter int unsigned DEF_YEL  = 2,
  parameter int unsigned DEF_WALK = 3
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Sensor,
  input  logic              Walk_Request,
  input  logic              Reprogram,
  input  logic [1:0]        Time_Parameter_Selector,
  input  logic [TVAL_W-1:0] Time_Value,
  input  logic              Night_Mode,
  output logic [6:0]        LEDs
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  localparam logic [6:0] LedMg    = 7'b0011000;
  localparam logic [6:0] LedMy    = 7'b0101000;
  localparam logic [6:0] LedWalk  = 7'b1001001;
  localparam logic [6:0] LedSg    = 7'b1000010;
  localparam logic [6:0] LedSy    = 7'b1000100;
  localparam logic [6:0] LedDark  = 7'b0000000;

  typedef enum logic [2:0] {
    StMg,
    StMy,
    StWalk,
    StSg,
    StSgx,
    StSy,
    StFlash
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [TVAL_W-1:0] rem_q, rem_d;
  logic [TVAL_W-1:0] t_base_q, t_base_d;
  logic [TVAL_W-1:0] t_ext_q, t_ext_d;
  logic [TVAL_W-1:0] t_yel_q, t_yel_d;
  logic [TVAL_W-1:0] t_walk_q, t_walk_d;
  logic              walk_q, walk_d;
  logic              flash_on_q, flash_on_d;

  logic              tick;
  logic              expire;
  logic [TVAL_W-1:0] prog_val;

  assign tick     = (div_q == DivW'(CLK_DIV - 1));
  // A zero-length interval would never expire, so the last second is also an end condition.
  assign expire   = tick && (rem_q <= TVAL_W'(1));
  assign prog_val = (Time_Value == '0) ? TVAL_W'(1) : Time_Value;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= StMg;
      div_q      <= '0;
      rem_q      <= TVAL_W'(DEF_BASE);
      t_base_q   <= TVAL_W'(DEF_BASE);
      t_ext_q    <= TVAL_W'(DEF_EXT);
      t_yel_q    <= TVAL_W'(DEF_YEL);
      t_walk_q   <= TVAL_W'(DEF_WALK);
      walk_q     <= 1'b0;
      flash_on_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      t_base_q   <= t_base_d;
      t_ext_q    <= t_ext_d;
      t_yel_q    <= t_yel_d;
      t_walk_q   <= t_walk_d;
      walk_q     <= walk_d;
      flash_on_q <= flash_on_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DivW'(1);
    rem_d      = tick ? rem_q - TVAL_W'(1) : rem_q;
    t_base_d   = t_base_q;
    t_ext_d    = t_ext_q;
    t_yel_d    = t_yel_q;
    t_walk_d   = t_walk_q;
    walk_d     = walk_q | Walk_Request;
    flash_on_d = flash_on_q;

    // On every expiry div_d is already zero, so only the new interval needs loading.
    unique case (state_q)
      StMg: begin
        if (expire) begin
          if (Night_Mode) begin
            state_d    = StFlash;
            flash_on_d = 1'b1;
          end else begin
            state_d = StMy;
            rem_d   = t_yel_q;
          end
        end
      end
      StMy: begin
        if (expire) begin
          if (walk_q) begin
            state_d = StWalk;
            rem_d   = t_walk_q;
          end else begin
            state_d = StSg;
            rem_d   = t_base_q;
          end
        end
      end
      StWalk: begin
        if (expire) begin
          state_d = StSg;
          rem_d   = t_base_q;
          walk_d  = 1'b0;
        end
      end
      StSg: begin
        if (expire) begin
          if (Sensor) begin
            state_d = StSgx;
            rem_d   = t_ext_q;
          end else begin
            state_d = StSy;
            rem_d   = t_yel_q;
          end
        end
      end
      StSgx: begin
        if (expire) begin
          state_d = StSy;
          rem_d   = t_yel_q;
        end
      end
      StSy: begin
        if (expire) begin
          if (Night_Mode) begin
            state_d    = StFlash;
            flash_on_d = 1'b1;
          end else begin
            state_d = StMg;
            rem_d   = t_base_q;
          end
        end
      end
      StFlash: begin
        rem_d = rem_q;
        if (!Night_Mode) begin
          state_d = StMg;
          div_d   = '0;
          rem_d   = t_base_q;
        end else if (tick) begin
          flash_on_d = !flash_on_q;
        end
      end
      default: begin
        state_d = StMg;
        div_d   = '0;
        rem_d   = t_base_q;
      end
    endcase

    // Reprogramming restarts the cycle from main green but never touches the walk latch.
    if (Reprogram) begin
      unique case (Time_Parameter_Selector)
        2'b00:   t_base_d = prog_val;
        2'b01:   t_ext_d  = prog_val;
        2'b10:   t_yel_d  = prog_val;
        default: t_walk_d = prog_val;
      endcase
      state_d = StMg;
      div_d   = '0;
      rem_d   = (Time_Parameter_Selector == 2'b00) ? prog_val : t_base_q;
      walk_d  = walk_q | Walk_Request;
    end
  end

  always_comb begin
    LEDs = LedDark;
    unique case (state_q)
      StMg:    LEDs = LedMg;
      StMy:    LEDs = LedMy;
      StWalk:  LEDs = LedWalk;
      StSg:    LEDs = LedSg;
      StSgx:   LEDs = LedSg;
      StSy:    LEDs = LedSy;
      StFlash: LEDs = flash_on_q ? LedMy : LedDark;
      default: LEDs = LedDark;
    endcase
  end

endmodule

// File: tb/tb_traffic_controller_param.sv
// Bench for traffic_controller_param: directed test-plan scenarios followed by random traffic,
// every cycle compared against a cycle-count reference model of the light sequence.
module tb_traffic_controller_param;

  localparam int D = 4;

  localparam logic [6:0] MG   = 7'b0011000;
  localparam logic [6:0] MY   = 7'b0101000;
  localparam logic [6:0] WALK = 7'b1001001;
  localparam logic [6:0] SG   = 7'b1000010;
  localparam logic [6:0] SY   = 7'b1000100;
  localparam logic [6:0] DARK = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor = 1'b0;
  logic       wreq = 1'b0;
  logic       reprog = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] tval = 4'd0;
  logic       night = 1'b0;
  logic [6:0] leds;

  int errors = 0;
  int checks = 0;

  // Reference model: phase name plus cycles left in the phase.
  string m_phase = "MG";
  int    m_left = 6 * D;
  int    m_flash = 0;
  int    m_base = 6, m_ext = 3, m_yel = 2, m_walk_t = 3;
  bit    m_walk = 1'b0;

  traffic_controller_param #(
    .CLK_DIV (D),
    .TVAL_W  (4),
    .DEF_BASE(6),
    .DEF_EXT (3),
    .DEF_YEL (2),
    .DEF_WALK(3)
  ) dut (
    .clk                    (clk),
    .Reset                  (rst),
    .Sensor                 (sensor),
    .Walk_Request           (wreq),
    .Reprogram              (reprog),
    .Time_Parameter_Selector(sel),
    .Time_Value             (tval),
    .Night_Mode             (night),
    .LEDs                   (leds)
  );

  always #5 clk = ~clk;

  task automatic model_enter(input string p);
    m_phase = p;
    m_flash = 0;
    if (p == "MG" || p == "SG") m_left = m_base * D;
    else if (p == "MY" || p == "SY") m_left = m_yel * D;
    else if (p == "WALK") m_left = m_walk_t * D;
    else if (p == "SGX") m_left = m_ext * D;
    else m_left = 0;
  endtask

  task automatic model_step();
    int v;
    bit old_walk;
    if (rst) begin
      m_base = 6; m_ext = 3; m_yel = 2; m_walk_t = 3;
      m_walk = 1'b0;
      model_enter("MG");
    end else if (reprog) begin
      v = (tval == 4'd0) ? 1 : int'(tval);
      case (sel)
        2'b00:   m_base = v;
        2'b01:   m_ext = v;
        2'b10:   m_yel = v;
        default: m_walk_t = v;
      endcase
      m_walk = m_walk | wreq;
      model_enter("MG");
    end else begin
      old_walk = m_walk;
      m_walk = m_walk | wreq;
      if (m_phase == "FLASH") begin
        if (!night) model_enter("MG");
        else m_flash++;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_phase == "MG") model_enter(night ? "FLASH" : "MY");
          else if (m_phase == "MY") model_enter(old_walk ? "WALK" : "SG");
          else if (m_phase == "WALK") begin
            m_walk = 1'b0;
            model_enter("SG");
          end
          else if (m_phase == "SG") model_enter(sensor ? "SGX" : "SY");
          else if (m_phase == "SGX") model_enter("SY");
          else model_enter(night ? "FLASH" : "MG");
        end
      end
    end
  endtask

  function automatic logic [6:0] model_leds();
    if (m_phase == "MG") return MG;
    if (m_phase == "MY") return MY;
    if (m_phase == "WALK") return WALK;
    if (m_phase == "SG" || m_phase == "SGX") return SG;
    if (m_phase == "SY") return SY;
    return (((m_flash / D) % 2) == 0) ? MY : DARK;
  endfunction

  // One clock edge with the currently driven inputs, then compare against the model.
  task automatic step();
    logic [6:0] exp;
    model_step();
    @(posedge clk);
    #1;
    exp = model_leds();
    checks++;
    assert (leds === exp) else begin
      errors++;
      $error("FAIL model[%s]: LEDs=%b expected %b", m_phase, leds, exp);
    end
  endtask

  // Current LEDs must equal v for n consecutive samples.
  task automatic expect_run(input logic [6:0] v, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (leds === v) else begin
        errors++;
        $error("FAIL %s[%0d]: LEDs=%b expected %b", tag, i, leds, v);
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset then idle, 64-cycle period.
    step();
    step();
    rst = 1'b0;
    expect_run(MG, 24, "s1_mg");
    expect_run(MY, 8, "s1_my");
    expect_run(SG, 24, "s1_sg");
    expect_run(SY, 8, "s1_sy");

    // 2: sensor held across SG end extends green once.
    sensor = 1'b1;
    expect_run(MG, 24, "s2_mg");
    expect_run(MY, 8, "s2_my");
    expect_run(SG, 36, "s2_sgx");
    sensor = 1'b0;
    expect_run(SY, 8, "s2_sy");

    // 3: one-cycle walk request in MG.
    wreq = 1'b1;
    expect_run(MG, 1, "s3_mg0");
    wreq = 1'b0;
    expect_run(MG, 23, "s3_mg");
    expect_run(MY, 8, "s3_my");
    expect_run(WALK, 12, "s3_walk");
    expect_run(SG, 24, "s3_sg");
    expect_run(SY, 8, "s3_sy");
    expect_run(MG, 24, "s3_mg2");
    expect_run(MY, 8, "s3_my2");
    expect_run(SG, 24, "s3_nowalk");
    expect_run(SY, 8, "s3_sy2");

    // 4: reprogram tYEL=5, then tBASE=0 (stored as 1).
    reprog = 1'b1; sel = 2'b10; tval = 4'd5;
    expect_run(MG, 1, "s4_prog");
    reprog = 1'b0;
    expect_run(MG, 24, "s4_mg");
    expect_run(MY, 20, "s4_my5");
    expect_run(SG, 24, "s4_sg");
    expect_run(SY, 20, "s4_sy5");
    reprog = 1'b1; sel = 2'b00; tval = 4'd0;
    expect_run(MG, 1, "s4_prog0");
    reprog = 1'b0;
    expect_run(MG, 4, "s4_mg1");
    expect_run(MY, 20, "s4_my");
    do_reset();

    // 5: night mode flashing, walk request during FLASH served afterwards.
    night = 1'b1;
    expect_run(MG, 24, "s5_mg");
    wreq = 1'b1;
    expect_run(MY, 1, "s5_on0");
    wreq = 1'b0;
    expect_run(MY, 3, "s5_on");
    expect_run(DARK, 4, "s5_off");
    expect_run(MY, 4, "s5_on2");
    expect_run(DARK, 2, "s5_off2");
    night = 1'b0;
    expect_run(DARK, 1, "s5_exit");
    expect_run(MG, 24, "s5_mg2");
    expect_run(MY, 8, "s5_my");
    expect_run(WALK, 12, "s5_walk");
    expect_run(SG, 1, "s5_sg");
    do_reset();

    // 6: reset mid-SGX with walk latched clears the latch.
    sensor = 1'b1;
    expect_run(MG, 24, "s6_mg");
    expect_run(MY, 8, "s6_my");
    wreq = 1'b1;
    expect_run(SG, 1, "s6_sg0");
    wreq = 1'b0;
    expect_run(SG, 29, "s6_sgx");
    rst = 1'b1;
    expect_run(SG, 1, "s6_rst");
    rst = 1'b0;
    sensor = 1'b0;
    expect_run(MG, 24, "s6_mg2");
    expect_run(MY, 8, "s6_my2");
    expect_run(SG, 1, "s6_nowalk");

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      reprog = ($urandom_range(0, 59) == 0);
      sel    = 2'($urandom_range(0, 3));
      tval   = 4'($urandom_range(0, 3));
      wreq   = ($urandom_range(0, 19) == 0);
      sensor = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 79) == 0) night = ~night;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
